// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with round-robin priority, a one-cycle turnaround
// gap between tenures and a hold-time limit that revokes long tenures.
// Every output comes straight from a flip-flop.
module bus_arbiter #(
    parameter int MAX_HOLD = 64
) (
    input  logic clk,
    input  logic rstn,
    input  logic req1,
    input  logic req2,
    input  logic busy,
    output logic grant1,
    output logic grant2,
    output logic msel,
    output logic timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2,
        GAP  = 2'd3
    } state_t;

    // Last cycle of a tenure: the counter value seen in the final grant cycle.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_reg, state_next;
    logic [7:0] hold_cnt_reg, hold_cnt_next;
    logic       last2_reg, last2_next;     // 1: master 2 was served last
    logic       msel_reg, msel_next;
    logic       timeout_reg, timeout_next;
    logic       grant1_reg, grant2_reg;
    logic       arm_reg;                   // arbitration enabled one edge after reset release

    // Next-state, hold counter, round-robin and output decode.
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        last2_next    = last2_reg;
        msel_next     = msel_reg;
        timeout_next  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (arm_reg && !busy) begin
                    if (req1 && req2) begin
                        // Both asking: serve whoever did not go last.
                        state_next = last2_reg ? GNT1 : GNT2;
                    end else if (req1) begin
                        state_next = GNT1;
                    end else if (req2) begin
                        state_next = GNT2;
                    end
                    if (state_next == GNT1) begin
                        msel_next     = 1'b0;
                        hold_cnt_next = 8'd0;
                    end else if (state_next == GNT2) begin
                        msel_next     = 1'b1;
                        hold_cnt_next = 8'd0;
                    end
                end
            end
            GNT1: begin
                if (!req1) begin
                    state_next = GAP;
                    last2_next = 1'b0;
                end else if (hold_cnt_reg == HOLD_LAST) begin
                    // Still requesting at the limit: revoke the tenure.
                    state_next   = GAP;
                    last2_next   = 1'b0;
                    timeout_next = 1'b1;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 8'd1;
                end
            end
            GNT2: begin
                if (!req2) begin
                    state_next = GAP;
                    last2_next = 1'b1;
                end else if (hold_cnt_reg == HOLD_LAST) begin
                    state_next   = GAP;
                    last2_next   = 1'b1;
                    timeout_next = 1'b1;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 8'd1;
                end
            end
            GAP: begin
                // Single turnaround cycle with no grant.
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and registered outputs; reset forces everything idle at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= 8'd0;
            last2_reg    <= 1'b1;
            msel_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            grant1_reg   <= 1'b0;
            grant2_reg   <= 1'b0;
            arm_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            last2_reg    <= last2_next;
            msel_reg     <= msel_next;
            timeout_reg  <= timeout_next;
            grant1_reg   <= (state_next == GNT1);
            grant2_reg   <= (state_next == GNT2);
            arm_reg      <= 1'b1;
        end
    end

    assign grant1  = grant1_reg;
    assign grant2  = grant2_reg;
    assign msel    = msel_reg;
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: one instance at the default hold limit and
// one at MAX_HOLD=4. Expected outputs are queued when inputs are driven and
// checked after the following rising edge.
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic req1_a = 1'b0, req2_a = 1'b0, busy_a = 1'b0;
    logic req1_b = 1'b0, req2_b = 1'b0, busy_b = 1'b0;
    logic g1_a, g2_a, msel_a, to_a;
    logic g1_b, g2_b, msel_b, to_b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] val;   // {grant1, grant2, msel, timeout}
        string      tag;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    bus_arbiter dut_a (
        .clk(clk), .rstn(rstn), .req1(req1_a), .req2(req2_a), .busy(busy_a),
        .grant1(g1_a), .grant2(g2_a), .msel(msel_a), .timeout(to_a)
    );

    bus_arbiter #(.MAX_HOLD(4)) dut_b (
        .clk(clk), .rstn(rstn), .req1(req1_b), .req2(req2_b), .busy(busy_b),
        .grant1(g1_b), .grant2(g2_b), .msel(msel_b), .timeout(to_b)
    );

    function automatic logic [3:0] obs(input logic sel_b);
        return sel_b ? {g1_b, g2_b, msel_b, to_b} : {g1_a, g2_a, msel_a, to_a};
    endfunction

    task automatic push(input logic [3:0] val, input string tag);
        exp_t e;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check(input logic sel_b);
        exp_t e;
        logic [3:0] o;
        o = obs(sel_b);
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %b with no expectation", o);
        end else begin
            e = sb.pop_front();
            assert (o === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed g1g2mselto=%b expected %b", e.tag, o, e.val);
            end
        end
        n_checks++;
        assert (!(o[3] && o[2])) else begin
            n_fail++;
            $error("FAIL both_grants: observed %b expected at most one grant", o);
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the edge.
    task automatic step(input logic sel_b, input logic r1, input logic r2, input logic b,
                        input logic [3:0] exp_val, input string tag);
        if (sel_b) begin
            req1_b = r1; req2_b = r2; busy_b = b;
        end else begin
            req1_a = r1; req2_a = r2; busy_a = b;
        end
        push(exp_val, tag);
        @(posedge clk);
        #1;
        check(sel_b);
        $display("step %-14s sel=%0d req=%b%b busy=%b out=%b", tag, sel_b, r1, r2, b, obs(sel_b));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with req1 already pending on instance A.
        req1_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push(4'b0000, "reset_a");
        check(1'b0);
        push(4'b0000, "reset_b");
        check(1'b1);
        rstn = 1'b1;

        // First grant only on the second edge after release.
        step(0, 1, 0, 0, 4'b0000, "arm_edge");
        step(0, 1, 0, 0, 4'b1000, "first_grant");
        for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 4'b1000, "hold_g1");
        step(0, 0, 0, 0, 4'b0000, "release_g1");
        step(0, 0, 0, 0, 4'b0000, "gap_g1");
        step(0, 0, 0, 0, 4'b0000, "idle_g1");

        // Fresh reset, then simultaneous requests: master 1 first.
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(0, 1, 1, 0, 4'b0000, "arm_both");
        step(0, 1, 1, 0, 4'b1000, "rr_first_m1");
        step(0, 1, 1, 0, 4'b1000, "rr_hold_m1");
        step(0, 0, 1, 0, 4'b0000, "rr_release_m1");
        step(0, 0, 1, 0, 4'b0000, "rr_idle");
        step(0, 0, 1, 0, 4'b0110, "rr_then_m2");
        step(0, 0, 1, 0, 4'b0110, "rr_hold_m2");
        step(0, 0, 0, 0, 4'b0010, "gap_msel_held");
        step(0, 0, 0, 0, 4'b0010, "idle_msel_held");

        // Busy blocks new grants but never revokes one.
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 4'b0010, "busy_block");
        step(0, 0, 1, 0, 4'b0110, "busy_fall_g2");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 4'b0110, "busy_mid_hold");
        step(0, 0, 0, 0, 4'b0010, "release_g2");
        step(0, 0, 0, 0, 4'b0010, "gap_g2");

        // Request withdrawn while blocked produces no grant.
        step(0, 1, 0, 1, 4'b0010, "req_busy");
        step(0, 0, 0, 0, 4'b0010, "req_dropped");
        step(0, 0, 0, 0, 4'b0010, "no_grant");

        // Asynchronous reset mid-tenure, with master 1 pending.
        step(0, 0, 1, 0, 4'b0110, "pre_rst_g2");
        step(0, 1, 1, 0, 4'b0110, "pre_rst_hold");
        rstn = 1'b0;
        #1;
        push(4'b0000, "async_reset");
        check(1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(0, 1, 0, 0, 4'b0000, "post_rst_arm");
        step(0, 1, 0, 0, 4'b1000, "post_rst_g1");
        step(0, 0, 0, 0, 4'b0000, "post_rst_rel");
        step(0, 0, 0, 0, 4'b0000, "post_rst_gap");

        // MAX_HOLD=4: revoke after exactly four grant cycles.
        step(1, 1, 1, 0, 4'b1000, "to_g1_c1");
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 4'b1000, "to_g1_hold");
        step(1, 1, 1, 0, 4'b0001, "timeout_pulse");
        step(1, 1, 1, 0, 4'b0000, "timeout_clear");
        step(1, 1, 1, 0, 4'b0110, "rr_after_to");
        step(1, 1, 1, 0, 4'b0110, "g2_hold");
        step(1, 1, 0, 0, 4'b0010, "g2_release");
        step(1, 1, 0, 0, 4'b0010, "g2_gap");
        step(1, 1, 0, 0, 4'b1000, "regrant_m1");

        // Release in the final allowed cycle is not a timeout.
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 4'b1000, "edge_hold");
        step(1, 0, 0, 0, 4'b0000, "edge_release");
        step(1, 0, 0, 0, 4'b0000, "edge_gap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 64, SHALL set the maximum consecutive grant cycles per tenure (legal range 2..255).
REQ-002 Port clk, input, 1, SHALL be the single system clock; all state updates on its rising edge.
REQ-003 Port rstn, input, 1, SHALL be the asynchronous, active-low reset.
REQ-004 Port req1, input, 1, SHALL be the master 1 bus request, held high for the whole transaction.
REQ-005 Port req2, input, 1, SHALL be the master 2 bus request, same semantics as req1.
REQ-006 Port busy, input, 1, SHALL be the slave busy indication; high means the bus is not accepting a new frame.
REQ-007 Port grant1, output, 1, SHALL be the bus grant to master 1.
REQ-008 Port grant2, output, 1, SHALL be the bus grant to master 2.
REQ-009 Port msel, output, 1, SHALL be the tx mux select: 0 routes master 1, 1 routes master 2.
REQ-010 Port timeout, output, 1, SHALL pulse high for one cycle when a tenure is revoked by the hold limit.

Function
REQ-011 The block SHALL be a registered FSM with states IDLE, GNT1, GNT2, GAP; all outputs driven from registers.
REQ-012 grant1 SHALL be high only in GNT1 and grant2 only in GNT2; grant1 and grant2 SHALL never be high together.
REQ-013 IDLE with busy=0 and exactly one request: go to the requester's GNTx; grant visible the cycle after the request is sampled.
REQ-014 IDLE with busy=0 and both requests: grant the master not held in the last-served register (round-robin); after reset, last-served = 2, so master 1 wins first.
REQ-015 IDLE with busy=1: stay in IDLE regardless of requests; no grant issued.
REQ-016 busy rising during GNTx SHALL NOT revoke the current grant.
REQ-017 In GNTx with reqx=0: go to GAP; grant low the next cycle; last-served := x.
REQ-018 GAP SHALL last exactly one cycle with no grant (bus turnaround), then go to IDLE.
REQ-019 Hold counter (8-bit) SHALL clear on entry to GNTx and increment each cycle in GNTx.
REQ-020 When the counter reaches MAX_HOLD-1 with reqx still high: go to GAP, assert timeout for that one transition cycle, last-served := x; grant was high for exactly MAX_HOLD cycles.
REQ-021 If reqx drops in the same cycle the counter reaches MAX_HOLD-1, this SHALL be a normal release: timeout stays 0.
REQ-022 A preempted master still requesting SHALL be regranted only via normal round-robin from IDLE.
REQ-023 msel SHALL change only on entry to GNTx (1 for GNT2, 0 for GNT1) and hold its value through GAP and IDLE.
REQ-024 A request dropped in IDLE before being granted SHALL cause no grant.

Reset
REQ-025 rstn=0 SHALL immediately force state IDLE, grant1=0, grant2=0, msel=0, timeout=0, counter=0, last-served=2, regardless of clk.
REQ-026 Reset asserted mid-tenure SHALL drop the grant asynchronously; after release, arbitration restarts from IDLE.
REQ-027 The first grant SHALL be possible on the second rising edge after rstn deasserts.

Verification
REQ-028 req1=1 only, busy=0 -> grant1=1 one cycle later, msel=0; req1 low after 10 cycles -> grant1 low next cycle, 1 GAP cycle, then IDLE.
REQ-029 req1=req2=1 simultaneously after reset -> grant1 first; on release, GAP, then grant2=1, msel=1; never both grants high.
REQ-030 busy=1 with req2=1 for 5 cycles -> no grant; busy falls -> grant2 one cycle later; busy rises mid-tenure -> grant2 held.
REQ-031 MAX_HOLD=4, req1 held high -> grant1 high exactly 4 cycles, timeout pulse of 1 cycle, GAP; with req2 high -> grant2 next.
REQ-032 rstn pulsed low during GNT2 -> grant2 and msel to 0 without a clock edge; req1 pending -> grant1 after reset release.
REQ-033 MAX_HOLD=4, req1 drops in the 4th grant cycle -> timeout=0, normal release.
